transition_gen: RTL and testbench

TRANSITION_GEN -- requirements
Module: transition_gen

---
 rtl/transition_gen.sv | 138 +++++++++++++
 tb/tb_transition_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/transition_gen.sv
// Level generator with minimum high/low hold times and a one-deep pending slot for the opposite level.
// Latency: an accepted request moves out at the next edge; no backpressure, excess requests are dropped with req_drop.
module transition_gen #(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rise_req,
    input  logic fall_req,
    output logic out,
    output logic low_high_done,
    output logic high_low_done,
    output logic busy,
    output logic req_drop
);

    typedef enum logic [1:0] {
        LOW_IDLE,
        LOW_HOLD,
        HIGH_IDLE,
        HIGH_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             lh_done_q, lh_done_d;
    logic             hl_done_q, hl_done_d;
    logic             drop_q, drop_d;

    logic is_high;
    logic is_hold;
    logic both_req;
    logic opp_req;
    logic same_req;
    logic go_opp;

    assign is_high  = (state_q == HIGH_IDLE) || (state_q == HIGH_HOLD);
    assign is_hold  = (state_q == LOW_HOLD)  || (state_q == HIGH_HOLD);
    assign both_req = rise_req && fall_req;
    // Requests are classified relative to the current level, so one pending bit suffices.
    assign opp_req  = is_high ? fall_req : rise_req;
    assign same_req = is_high ? rise_req : fall_req;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        lh_done_d = 1'b0;
        hl_done_d = 1'b0;
        drop_d    = 1'b0;
        go_opp    = 1'b0;

        case (state_q)
            LOW_IDLE, HIGH_IDLE: begin
                if (both_req || same_req) begin
                    drop_d = 1'b1;
                end else if (opp_req) begin
                    go_opp = 1'b1;
                end
            end

            LOW_HOLD, HIGH_HOLD: begin
                if (cnt_q == '0) begin
                    if (pend_q) begin
                        // Pending request fires now; anything arriving this cycle finds the slot full.
                        go_opp = 1'b1;
                        pend_d = 1'b0;
                        if (rise_req || fall_req) begin
                            drop_d = 1'b1;
                        end
                    end else begin
                        // Hold expiring with nothing pending behaves like the idle state of this level.
                        state_d = is_high ? HIGH_IDLE : LOW_IDLE;
                        if (both_req || same_req) begin
                            drop_d = 1'b1;
                        end else if (opp_req) begin
                            go_opp = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (both_req || same_req || (opp_req && pend_q)) begin
                        drop_d = 1'b1;
                    end else if (opp_req) begin
                        pend_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = LOW_IDLE;
            end
        endcase

        if (go_opp) begin
            if (is_high) begin
                state_d   = LOW_HOLD;
                cnt_d     = LOW_LOAD;
                hl_done_d = 1'b1;
            end else begin
                state_d   = HIGH_HOLD;
                cnt_d     = HIGH_LOAD;
                lh_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOW_IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            lh_done_q <= 1'b0;
            hl_done_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            lh_done_q <= lh_done_d;
            hl_done_q <= hl_done_d;
            drop_q    <= drop_d;
        end
    end

    assign out           = is_high;
    assign busy          = is_hold || pend_q;
    assign low_high_done = lh_done_q;
    assign high_low_done = hl_done_q;
    assign req_drop      = drop_q;

endmodule

// File: tb/tb_transition_gen.sv
// Directed bench for transition_gen (MIN_HIGH=3, MIN_LOW=2); expected output vectors are queued per step.
module tb_transition_gen;

    localparam int MH = 3;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rise_req = 1'b0;
    logic fall_req = 1'b0;
    logic out, low_high_done, high_low_done, busy, req_drop;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [4:0] sb_q[$];

    always #5 clk = ~clk;

    transition_gen #(
        .MIN_HIGH(MH),
        .MIN_LOW (ML),
        .CNT_W   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rise_req     (rise_req),
        .fall_req     (fall_req),
        .out          (out),
        .low_high_done(low_high_done),
        .high_low_done(high_low_done),
        .busy         (busy),
        .req_drop     (req_drop)
    );

    // Vector order: {out, low_high_done, high_low_done, busy, req_drop}
    function automatic logic [4:0] obs();
        return {out, low_high_done, high_low_done, busy, req_drop};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic f, input logic [4:0] e);
        logic [4:0] want;
        @(negedge clk);
        rise_req = r;
        fall_req = f;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        chk(tag, {3'b000, obs()}, {3'b000, want});
    endtask

    initial begin
        logic prev_out;
        int   run_len;
        int   n_chg;
        bit   seen;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {3'b000, obs()}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step("idle_after_reset", 1'b0, 1'b0, 5'b00000);

        // First rise after reset, full high hold, then high idle
        step("rise_c1",      1'b1, 1'b0, 5'b11010);
        step("rise_c2",      1'b0, 1'b0, 5'b10010);
        step("rise_c3",      1'b0, 1'b0, 5'b10010);
        step("rise_c4_idle", 1'b0, 1'b0, 5'b10000);
        step("rise_in_high_idle_drop", 1'b1, 1'b0, 5'b10001);
        step("drop_pulse_end",         1'b0, 1'b0, 5'b10000);
        step("fall_from_idle",  1'b0, 1'b1, 5'b00110);
        step("low_hold_c2",     1'b0, 1'b0, 5'b00010);
        step("low_idle",        1'b0, 1'b0, 5'b00000);
        step("both_req_drop",   1'b1, 1'b1, 5'b00001);
        step("both_req_after",  1'b0, 1'b0, 5'b00000);
        step("fall_in_low_idle_drop", 1'b0, 1'b1, 5'b00001);

        // Fall arriving during high hold is pended and executes at expiry
        step("pend_rise",   1'b1, 1'b0, 5'b11010);
        step("pend_fall",   1'b0, 1'b1, 5'b10010);
        step("pend_hold3",  1'b0, 1'b0, 5'b10010);
        step("pend_exec",   1'b0, 1'b0, 5'b00110);
        step("pend_low2",   1'b0, 1'b0, 5'b00010);
        step("pend_lowidl", 1'b0, 1'b0, 5'b00000);

        // Second fall while slot is full is dropped
        step("full_rise",   1'b1, 1'b0, 5'b11010);
        step("full_fall1",  1'b0, 1'b1, 5'b10010);
        step("full_fall2",  1'b0, 1'b1, 5'b10011);
        step("full_exec",   1'b0, 1'b0, 5'b00110);
        step("full_low2",   1'b0, 1'b0, 5'b00010);
        step("full_lowidl", 1'b0, 1'b0, 5'b00000);

        // Same-level drop in hold, requests landing on the expiry cycle
        step("same_rise",       1'b1, 1'b0, 5'b11010);
        step("same_rise_drop",  1'b1, 1'b0, 5'b10011);
        step("same_hold3",      1'b0, 1'b0, 5'b10010);
        step("expiry_fall_now", 1'b0, 1'b1, 5'b00110);
        step("low_hold_pend",   1'b1, 1'b0, 5'b00010);
        step("low_pend_exec",   1'b0, 1'b0, 5'b11010);
        step("exp_hold2",       1'b0, 1'b0, 5'b10010);
        step("exp_hold3",       1'b0, 1'b0, 5'b10010);
        step("expiry_same_drop",1'b1, 1'b0, 5'b10001);
        step("exp_high_idle",   1'b0, 1'b0, 5'b10000);

        // Asynchronous reset mid high hold with a pending fall
        step("ar_fall",    1'b0, 1'b1, 5'b00110);
        step("ar_low2",    1'b0, 1'b0, 5'b00010);
        step("ar_lowidl",  1'b0, 1'b0, 5'b00000);
        step("ar_rise",    1'b1, 1'b0, 5'b11010);
        step("ar_pend",    1'b0, 1'b1, 5'b10010);
        #2;
        rise_req = 1'b0;
        fall_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_reset_now", {3'b000, obs()}, 8'h00);
        @(posedge clk);
        #1;
        chk("reset_held_no_done", {3'b000, obs()}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step("post_reset_rise", 1'b1, 1'b0, 5'b11010);
        step("post_reset_c2",   1'b0, 1'b0, 5'b10010);
        step("post_reset_c3",   1'b0, 1'b0, 5'b10010);
        step("post_reset_idle", 1'b0, 1'b0, 5'b10000);

        // Alternating requests: minimum run lengths and done/edge coincidence
        prev_out = out;
        run_len  = 1;
        n_chg    = 0;
        seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rise_req = (i % 2) == 1;
            fall_req = (i % 2) == 0;
            @(posedge clk);
            #1;
            if (out !== prev_out) begin
                if (seen) begin
                    if (prev_out)
                        chk("alt_high_run_min", {7'd0, run_len >= MH}, 8'd1);
                    else
                        chk("alt_low_run_min", {7'd0, run_len >= ML}, 8'd1);
                end
                seen    = 1'b1;
                n_chg++;
                run_len = 1;
            end else begin
                run_len++;
            end
            chk("alt_lh_done_edge", {7'd0, low_high_done}, {7'd0, out & ~prev_out});
            chk("alt_hl_done_edge", {7'd0, high_low_done}, {7'd0, ~out & prev_out});
            prev_out = out;
        end
        @(negedge clk);
        rise_req = 1'b0;
        fall_req = 1'b0;
        chk("alt_enough_changes", {7'd0, n_chg >= 6}, 8'd1);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
